// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the frame synchronisation controller.
// Holds the IDLE/GO state enum, the frame divider width, the overrun
// counter width, its saturation value, and a saturating increment helper.
package frame_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GO   = 1'b1
    } state_e;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned OVR_W = 8;

    localparam logic [OVR_W-1:0] OVR_MAX = OVR_W'(255);

    // Increment that holds at OVR_MAX instead of wrapping.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == OVR_MAX) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/frame_sync_ctrl_edge_detect.sv
// Rising-edge detector for a level that is already in the clock domain.
// Ports:
//   clock     - sole clock
//   reset     - synchronous active-high reset; clears the previous sample
//   sig_i     - level to watch
//   rise_c_o  - one-cycle pulse, high when sig_i==1 and previous sample==0
// The previous sample clears on reset, so a level already high in the first
// cycle after reset is reported as an edge.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic rise_c_o
);

    logic prev_q;

    // Previous-sample register.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_c_o = sig_i & ~prev_q;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation controller between the VGA end-of-frame level and
// a CPU computing ball positions. A frame is granted (frame_go=1) once per
// FRAME_DIV rising edges of screenEnd; a cpu_done pulse while granted
// commits the CPU ball position to the display registers.
// Parameters:
//   FRAME_DIV - screenEnd rising edges per granted frame (1..255)
//   CNT_W     - width of frame_cnt
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   screenEnd             - VGA end-of-frame level
//   cpu_done              - one-cycle pulse: CPU update for the frame is done
//   ball_x_cpu/ball_y_cpu - CPU-written ball position
//   ball_xinit/ball_yinit - ball position loaded on reset
//   frame_go              - high while the CPU may compute the current frame
//   disp_x/disp_y         - committed ball position seen by the display
//   frame_cnt             - committed-frame count (wraps)
//   overrun_cnt           - saturating count of missed frames; present only
//                           when FRAME_SYNC_OVERRUN_CNT_EN is defined
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             screenEnd,
    input  logic             cpu_done,
    input  logic [31:0]      ball_x_cpu,
    input  logic [31:0]      ball_y_cpu,
    input  logic [31:0]      ball_xinit,
    input  logic [31:0]      ball_yinit,
    output logic             frame_go,
    output logic [31:0]      disp_x,
    output logic [31:0]      disp_y,
    output logic [CNT_W-1:0] frame_cnt
`ifdef FRAME_SYNC_OVERRUN_CNT_EN
    ,
    output logic [OVR_W-1:0] overrun_cnt
`endif
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    state_e           state_q;
    logic             frame_go_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      disp_x_q;
    logic [31:0]      disp_y_q;
    logic             rise_c;
`ifdef FRAME_SYNC_OVERRUN_CNT_EN
    logic [OVR_W-1:0] ovr_q;
`endif

    edge_detect u_edge (
        .clock    (clock),
        .reset    (reset),
        .sig_i    (screenEnd),
        .rise_c_o (rise_c)
    );

    // Frame grant FSM with its registered outputs and datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_go_q <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            disp_x_q   <= ball_xinit;
            disp_y_q   <= ball_yinit;
`ifdef FRAME_SYNC_OVERRUN_CNT_EN
            ovr_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // cpu_done is ignored here: nothing is granted to commit.
                    if (rise_c) begin
                        if (div_q == DIV_LAST) begin
                            state_q    <= GO;
                            frame_go_q <= 1'b1;
                            div_q      <= '0;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                GO: begin
                    if (cpu_done) begin
                        disp_x_q <= ball_x_cpu;
                        disp_y_q <= ball_y_cpu;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        // A coincident edge re-grants at once; otherwise wait.
                        if (!rise_c) begin
                            state_q    <= IDLE;
                            frame_go_q <= 1'b0;
                        end
                    end
`ifdef FRAME_SYNC_OVERRUN_CNT_EN
                    else if (rise_c) begin
                        ovr_q <= sat_inc(ovr_q);
                    end
`endif
                end
                default: begin
                    state_q    <= IDLE;
                    frame_go_q <= 1'b0;
                end
            endcase
        end
    end

    assign frame_go  = frame_go_q;
    assign disp_x    = disp_x_q;
    assign disp_y    = disp_y_q;
    assign frame_cnt = cnt_q;
`ifdef FRAME_SYNC_OVERRUN_CNT_EN
    assign overrun_cnt = ovr_q;
`endif

endmodule

// File: doc/frame_sync_ctrl.md
FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

Interface
REQ-001 Parameter FRAME_DIV, default 1, meaning: one update frame is granted per FRAME_DIV rising edges of screenEnd; legal range 1..255.
REQ-002 Parameter CNT_W, default 16, meaning: width of frame_cnt.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 screenEnd  in  1  VGA end-of-frame level; asynchronous to game logic but already in the clock domain.
REQ-006 cpu_done  in  1  one-cycle pulse from the CPU-side register file: ball update for this frame is complete.
REQ-007 ball_x_cpu  in  32  CPU-written ball x.
REQ-008 ball_y_cpu  in  32  CPU-written ball y.
REQ-009 ball_xinit  in  32  initial ball x.
REQ-010 ball_yinit  in  32  initial ball y.
REQ-011 frame_go  out  1  level; high while the CPU may compute the current frame.
REQ-012 disp_x  out  32  committed ball x seen by the display.
REQ-013 disp_y  out  32  committed ball y seen by the display.
REQ-014 frame_cnt  out  CNT_W  committed-frame count.
REQ-015 overrun_cnt  out  8  frames missed by the CPU (present only with the macro, see Configuration).

Function
REQ-016 The block SHALL detect a rising edge as screenEnd==1 with the registered previous sample ==0.
REQ-017 The block SHALL implement states IDLE and GO; frame_go SHALL be 1 exactly when the state is GO.
REQ-018 In IDLE, each rising edge SHALL increment an 8-bit divider; when the divider equals FRAME_DIV-1 on an edge, the state SHALL become GO next cycle and the divider SHALL clear.
REQ-019 The latency from a granting edge sampled in cycle n to frame_go=1 SHALL be one cycle, so frame_go is high in cycle n+1.
REQ-020 In GO, cpu_done=1 SHALL, on the same clock edge, load disp_x<=ball_x_cpu and disp_y<=ball_y_cpu, increment frame_cnt, and return the state to IDLE.
REQ-021 frame_cnt SHALL wrap from all-ones to 0.
REQ-022 cpu_done in IDLE SHALL be ignored, with no load and no count change.
REQ-023 disp_x and disp_y SHALL change only on a commit, never mid-frame.
REQ-024 A rising edge in GO without cpu_done is an overrun: the state SHALL stay GO and the divider SHALL not advance.
REQ-025 A rising edge in GO coinciding with cpu_done SHALL commit per REQ-020 and then stay in GO (a new frame is granted immediately); this is not an overrun.
REQ-026 With FRAME_DIV=1, every edge in IDLE SHALL grant.

Reset
REQ-027 On reset, the block SHALL set state=IDLE, frame_go=0, divider=0, previous screenEnd sample=0, frame_cnt=0, and overrun_cnt=0.
REQ-028 On reset, disp_x and disp_y SHALL load ball_xinit and ball_yinit.
REQ-029 Reset SHALL take priority over all events, including mid-GO and coincident cpu_done.
REQ-030 If screenEnd is high in the first cycle after reset, it SHALL count as a rising edge.

Configuration
REQ-031 Macro FRAME_SYNC_OVERRUN_CNT_EN, when defined, SHALL include overrun_cnt: it increments per REQ-024 event and saturates at 255.
REQ-032 When FRAME_SYNC_OVERRUN_CNT_EN is undefined, the overrun_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-033 Package frame_sync_pkg SHALL hold the state enum (IDLE, GO), the divider width (8), and the overrun saturation constant (255).
REQ-034 Rising-edge detection SHALL be a sub-module named edge_detect (registered previous sample, one-cycle pulse output).

Verification
REQ-035 Reset with ball_xinit=320 and ball_yinit=240 -> disp_x=320, disp_y=240, frame_go=0, frame_cnt=0.
REQ-036 FRAME_DIV=1, screenEnd rising edge at cycle 10 -> frame_go=1 at cycle 11; cpu_done at cycle 20 with ball_x_cpu=5, ball_y_cpu=7 -> cycle 21: disp=(5,7), frame_cnt=1, frame_go=0.
REQ-037 FRAME_DIV=3, six edges with a prompt cpu_done each frame -> frame_go asserted exactly twice, after edges 3 and 6.
REQ-038 Two edges in GO with no cpu_done -> overrun_cnt=2 and frame_go held at 1; after 300 such edges -> overrun_cnt=255.
REQ-039 Edge coinciding with cpu_done in GO -> commit occurs, frame_go stays 1, overrun_cnt unchanged.
REQ-040 Reset asserted while in GO with cpu_done=1 -> no commit; disp returns to the init values and frame_cnt=0.
